// File: rtl/i2s_target_port.sv
// i2s_target_port: I2S target port that oversamples an external BCLK/LRCK/SD stream,
// deserialises L/R words, serialises TX words on sd_out and tracks framing lock.
module i2s_target_port #(
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 6,
  parameter int TIMEOUT = 256
) (
  input  logic              clk_audio,
  input  logic              reset,
  input  logic              sclk_in,
  input  logic              lrck_in,
  input  logic              sd_in,
  output logic              sd_out,
  input  logic [DATA_W-1:0] l_data_tx,
  input  logic [DATA_W-1:0] r_data_tx,
  output logic [DATA_W-1:0] l_data_rx,
  output logic [DATA_W-1:0] r_data_rx,
  output logic              new_sample_pulse,
  output logic              locked,
  output logic              frame_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SLOT_W-1:0] SLOT_MAX = '1;
  localparam logic [SLOT_W-1:0] DW = SLOT_W'(DATA_W);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_SAT = TW'(TIMEOUT);
  logic [1:0] sclk_s, lrck_s, sd_s;
  logic sclk_d, rise, fall, boundary, good, synced, prev_lrck, chan, pulse_pend, tout;
  logic [SLOT_W-1:0] slot_cnt, last_len, next_slot;
  logic [2:0] run, run_nx;
  logic [TW-1:0] tcnt;
  logic [DATA_W-1:0] rx_shift, tx_shift, l_hold, r_hold;
  assign rise = sclk_s[1] & ~sclk_d;
  assign fall = ~sclk_s[1] & sclk_d;
  assign boundary = rise && (lrck_s[1] != prev_lrck);
  assign next_slot = slot_cnt + 1'b1;
  assign good = slot_cnt >= DW;
  // run counts consecutive good halves of identical length, saturating at 4
  assign run_nx = (run != 3'd0 && slot_cnt == last_len) ? (run == 3'd4 ? run : run + 3'd1) : 3'd1;
  assign tout = !rise && !fall && tcnt == T_LAST;
  always_ff @(posedge clk_audio) begin
    if (reset) begin
      sclk_s <= '0;
      lrck_s <= '0;
      sd_s <= '0;
      sclk_d <= 1'b0;
      sd_out <= 1'b0;
      l_data_rx <= '0;
      r_data_rx <= '0;
      new_sample_pulse <= 1'b0;
      locked <= 1'b0;
      frame_err <= 1'b0;
      synced <= 1'b0;
      prev_lrck <= 1'b0;
      chan <= 1'b0;
      pulse_pend <= 1'b0;
      slot_cnt <= '0;
      last_len <= '0;
      run <= '0;
      tcnt <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      l_hold <= '0;
      r_hold <= '0;
    end else begin
      sclk_s <= {sclk_s[0], sclk_in};
      lrck_s <= {lrck_s[0], lrck_in};
      sd_s <= {sd_s[0], sd_in};
      sclk_d <= sclk_s[1];
      frame_err <= 1'b0;
      pulse_pend <= 1'b0;
      new_sample_pulse <= pulse_pend & locked;
      tcnt <= (rise || fall) ? '0 : (tcnt == T_SAT ? tcnt : tcnt + 1'b1);
      if (tout) begin
        locked <= 1'b0;
        run <= '0;
        synced <= 1'b0;
      end
      if (rise) begin
        prev_lrck <= lrck_s[1];
        if (boundary) begin
          slot_cnt <= '0;
          chan <= lrck_s[1];
          synced <= 1'b1;
          if (!lrck_s[1]) begin
            l_hold <= l_data_tx;
            r_hold <= r_data_tx;
            tx_shift <= l_data_tx;
          end else begin
            tx_shift <= r_hold;
          end
          if (synced && good) begin
            if (chan) r_data_rx <= rx_shift;
            else l_data_rx <= rx_shift;
            pulse_pend <= chan;
            run <= run_nx;
            last_len <= slot_cnt;
            locked <= run_nx == 3'd4;
          end else if (synced) begin
            frame_err <= 1'b1;
            locked <= 1'b0;
            run <= '0;
          end
        end else if (slot_cnt != SLOT_MAX) begin
          slot_cnt <= next_slot;
          if (next_slot <= DW) rx_shift <= {rx_shift[DATA_W-2:0], sd_s[1]};
          if (next_slot == SLOT_MAX && synced) begin
            frame_err <= 1'b1;
            locked <= 1'b0;
            run <= '0;
            synced <= 1'b0;
          end
        end
      end
      if (fall) begin
        sd_out <= (next_slot != '0 && next_slot <= DW) ? tx_shift[DATA_W-1] : 1'b0;
        if (next_slot != '0 && next_slot <= DW) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
    end
  end
endmodule

// File: tb/tb_i2s_target_port.sv
// tb_i2s_target_port: drives an I2S master stream and checks the port against a half-frame level model.
module tb_i2s_target_port;
  localparam int DW = 24;
  logic clk_audio = 1'b0, reset = 1'b1, sclk_in = 1'b0, lrck_in = 1'b0, sd_in = 1'b0;
  logic sd_out, new_sample_pulse, locked, frame_err;
  logic [DW-1:0] l_data_tx, r_data_tx, l_data_rx, r_data_rx;
  int total = 0, bad = 0, np_seen = 0, fe_seen = 0, exp_np = 0, exp_fe = 0;
  bit m_sync, m_prev, m_chan, m_locked, tx_rand;
  int m_len, m_streak, m_ref;
  logic [DW-1:0] m_word, m_l, m_r, h_l, h_r, m_tx;

  always #5 clk_audio = ~clk_audio;

  i2s_target_port dut (
    .clk_audio(clk_audio), .reset(reset), .sclk_in(sclk_in), .lrck_in(lrck_in), .sd_in(sd_in),
    .sd_out(sd_out), .l_data_tx(l_data_tx), .r_data_tx(r_data_tx), .l_data_rx(l_data_rx),
    .r_data_rx(r_data_rx), .new_sample_pulse(new_sample_pulse), .locked(locked), .frame_err(frame_err)
  );

  always @(posedge clk_audio) begin
    if (new_sample_pulse) np_seen++;
    if (frame_err) fe_seen++;
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sync = 0; m_prev = 0; m_chan = 0; m_locked = 0;
    m_len = 0; m_streak = 0; m_ref = 0;
    m_word = '0; m_l = '0; m_r = '0; h_l = '0; h_r = '0; m_tx = '0;
  endtask

  // evaluate the half that just ended, then open the new one
  task automatic model_boundary(input bit c, input logic [DW-1:0] w);
    if (m_sync) begin
      if (m_len >= DW + 1) begin
        if (m_chan) m_r = m_word;
        else m_l = m_word;
        m_streak = (m_streak > 0 && m_len == m_ref) ? m_streak + 1 : 1;
        m_ref = m_len;
        m_locked = m_streak >= 4;
        if (m_chan && m_locked) exp_np++;
      end else begin
        exp_fe++;
        m_locked = 0;
        m_streak = 0;
      end
    end
    m_sync = 1;
    if (!c) begin
      h_l = l_data_tx;
      h_r = r_data_tx;
    end
    m_tx = c ? h_r : h_l;
    m_chan = c;
    m_len = 0;
    m_word = w;
  endtask

  task automatic slot(input bit c, input bit d, output bit so);
    @(negedge clk_audio);
    sclk_in = 1'b0; lrck_in = c; sd_in = d;
    repeat (4) @(negedge clk_audio);
    sclk_in = 1'b1;
    so = sd_out;
    repeat (3) @(negedge clk_audio);
  endtask

  task automatic send_half(input bit c, input int n, input logic [DW-1:0] w,
                           input int pause_at = -1, input int reset_at = -1);
    bit so, bnd;
    logic [DW-1:0] txw;
    txw = '0;
    bnd = (c != m_prev);
    for (int s = 0; s < n; s++) begin
      slot(c, (s >= 1 && s <= DW) ? w[DW-s] : 1'b0, so);
      if (s >= 1 && s <= DW) txw[DW-s] = so;
      if (s == 0) begin
        if (bnd) model_boundary(c, w);
        m_prev = c;
      end
      if (s == 1) begin
        check("locked", 48'(locked), 48'(m_locked));
        check("l_rx", 48'(l_data_rx), 48'(m_l));
        check("r_rx", 48'(r_data_rx), 48'(m_r));
        check("pulses", 48'(np_seen), 48'(exp_np));
        check("frame_errs", 48'(fe_seen), 48'(exp_fe));
      end
      if (s == 5 && tx_rand) begin
        l_data_tx = 24'($urandom);
        r_data_tx = 24'($urandom);
      end
      if (s == pause_at) begin
        repeat (300) @(negedge clk_audio);
        m_locked = 0; m_streak = 0; m_sync = 0;
        check("timeout_locked", 48'(locked), 48'(0));
      end
      if (s == reset_at) begin
        @(negedge clk_audio);
        sclk_in = 1'b0;
        reset = 1'b1;
        @(negedge clk_audio);
        check("rst_rx", {l_data_rx, r_data_rx}, 48'(0));
        check("rst_flags", 48'({locked, sd_out, new_sample_pulse, frame_err}), 48'(0));
        reset = 1'b0;
        model_reset();
        return;
      end
    end
    m_len += n;
    if (bnd && n > DW && pause_at < 0) check("tx_word", 48'(txw), 48'(m_tx));
  endtask

  task automatic frames(input int k, input int nl, input int nr, input bit rnd);
    for (int i = 0; i < k; i++) begin
      send_half(0, nl, rnd ? 24'($urandom) : 24'hA5A5A5);
      send_half(1, nr, rnd ? 24'($urandom) : 24'h5A5A5A);
    end
  endtask

  initial begin
    l_data_tx = 24'h123456;
    r_data_tx = 24'hABCDEF;
    tx_rand = 0;
    model_reset();
    repeat (5) @(negedge clk_audio);
    check("init_rx", {l_data_rx, r_data_rx}, 48'(0));
    check("init_flags", 48'({locked, sd_out, new_sample_pulse, frame_err}), 48'(0));
    reset = 1'b0;
    send_half(0, 4, '0);
    send_half(1, 32, 24'h5A5A5A);
    frames(5, 32, 32, 0);
    check("locked_64", 48'(locked), 48'(1));
    tx_rand = 1;
    frames(5, 25, 25, 1);
    frames(3, 24, 24, 1);
    frames(5, 32, 32, 1);
    send_half(0, 16, 24'($urandom));
    send_half(1, 32, 24'($urandom));
    frames(4, 32, 32, 1);
    send_half(0, 32, 24'($urandom), 10);
    send_half(1, 32, 24'($urandom));
    frames(4, 32, 32, 1);
    send_half(0, 32, 24'($urandom));
    send_half(1, 32, 24'($urandom), -1, 12);
    send_half(1, 32, 24'($urandom));
    frames(4, 32, 32, 1);
    send_half(0, 4, '0);
    check("end_pulses", 48'(np_seen), 48'(exp_np));
    check("end_frame_errs", 48'(fe_seen), 48'(exp_fe));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
